// File: rtl/signed_divider_pkg.sv
// Shared definitions for the sequential signed divider: state encoding,
// default operand widths and the two's-complement most-negative constant.
package signed_divider_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int DEF_A_SIZE = 16;
  localparam int DEF_B_SIZE = 8;

  // Most-negative two's-complement value of the given width, right-aligned.
  function automatic logic [63:0] most_negative(input int width);
    most_negative = 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/signed_divider_twos_abs.sv
// Magnitude and sign of a two's-complement value; the magnitude is one bit
// wider so the most-negative input maps to a correct positive value.
module twos_abs #(
  parameter int width = 8
) (
  input  logic [width-1:0] value,
  output logic [width:0]   mag,
  output logic             sign
);

  logic [width:0] ext_s;

  assign sign  = value[width-1];
  assign ext_s = {value[width-1], value};
  assign mag   = sign ? (~ext_s + {{width{1'b0}}, 1'b1}) : ext_s;

endmodule

// File: rtl/signed_divider.sv
// Iterative restoring signed divider: one quotient bit per cycle behind a
// start/busy/done handshake, truncating toward zero, with dbz/ovf flags.
module signed_divider
  import signed_divider_pkg::*;
#(
  parameter int a_size = DEF_A_SIZE,
  parameter int b_size = DEF_B_SIZE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [a_size-1:0] a,
  input  logic [b_size-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [a_size-1:0] q,
  output logic [b_size-1:0] r,
  output logic              dbz,
  output logic              ovf
);

  localparam int CW = $clog2(a_size);
  localparam logic [CW-1:0]     LAST_CNT = CW'(a_size - 1);
  localparam logic [a_size-1:0] A_MIN    = a_size'(most_negative(a_size));
  localparam logic [b_size:0]   ONE_B    = (b_size + 1)'(1);

  state_t            state_r;
  logic [CW-1:0]     cnt_r;
  logic              sign_a_r;
  logic              sign_b_r;
  logic              dbz_pend_r;
  logic              ovf_pend_r;
  logic [a_size-1:0] dq_r;
  logic [b_size:0]   abs_b_r;
  logic [b_size:0]   rem_r;
  logic              busy_r;
  logic              done_r;
  logic [a_size-1:0] q_r;
  logic [b_size-1:0] r_r;
  logic              dbz_r;
  logic              ovf_r;

  logic [a_size:0]   mag_a_s;
  logic              sign_a_s;
  logic [b_size:0]   mag_b_s;
  logic              sign_b_s;
  logic              ovf_s;
  logic [b_size+1:0] shifted_s;
  logic [b_size+1:0] diff_s;
  logic [a_size-1:0] q_fix_s;
  logic [b_size-1:0] r_fix_s;

  twos_abs #(.width(a_size)) u_abs_a (.value(a), .mag(mag_a_s), .sign(sign_a_s));
  twos_abs #(.width(b_size)) u_abs_b (.value(b), .mag(mag_b_s), .sign(sign_b_s));

  assign ovf_s = sign_a_s & sign_b_s & (mag_a_s == {1'b0, A_MIN}) & (mag_b_s == ONE_B);

  // Restoring step: the dividend register feeds its MSB into the partial
  // remainder; a borrow out of the trial subtraction means "restore".
  assign shifted_s = {rem_r, dq_r[a_size-1]};
  assign diff_s    = shifted_s - {1'b0, abs_b_r};

  // Sign correction and special-case results applied in FIX.
  always_comb begin
    q_fix_s = dq_r;
    r_fix_s = rem_r[b_size-1:0];
    if (dbz_pend_r) begin
      q_fix_s = {a_size{1'b1}};
      r_fix_s = {b_size{1'b0}};
    end else if (ovf_pend_r) begin
      q_fix_s = A_MIN;
      r_fix_s = {b_size{1'b0}};
    end else begin
      if (sign_a_r ^ sign_b_r) begin
        q_fix_s = -dq_r;
      end else begin
        q_fix_s = dq_r;
      end
      if (sign_a_r) begin
        r_fix_s = -rem_r[b_size-1:0];
      end else begin
        r_fix_s = rem_r[b_size-1:0];
      end
    end
  end

  // Control FSM, iteration counter, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      cnt_r      <= {CW{1'b0}};
      sign_a_r   <= 1'b0;
      sign_b_r   <= 1'b0;
      dbz_pend_r <= 1'b0;
      ovf_pend_r <= 1'b0;
      dq_r       <= {a_size{1'b0}};
      abs_b_r    <= {(b_size + 1){1'b0}};
      rem_r      <= {(b_size + 1){1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      q_r        <= {a_size{1'b0}};
      r_r        <= {b_size{1'b0}};
      dbz_r      <= 1'b0;
      ovf_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            state_r    <= ST_CALC;
            busy_r     <= 1'b1;
            cnt_r      <= {CW{1'b0}};
            sign_a_r   <= sign_a_s;
            sign_b_r   <= sign_b_s;
            dbz_pend_r <= (b == {b_size{1'b0}});
            ovf_pend_r <= ovf_s;
            dq_r       <= mag_a_s[a_size-1:0];
            abs_b_r    <= mag_b_s;
            rem_r      <= {(b_size + 1){1'b0}};
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_CALC: begin
          dq_r  <= {dq_r[a_size-2:0], ~diff_s[b_size+1]};
          rem_r <= diff_s[b_size+1] ? shifted_s[b_size:0] : diff_s[b_size:0];
          if (cnt_r == LAST_CNT) begin
            state_r <= ST_FIX;
            cnt_r   <= {CW{1'b0}};
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        ST_FIX: begin
          q_r     <= q_fix_s;
          r_r     <= r_fix_s;
          dbz_r   <= dbz_pend_r;
          ovf_r   <= ovf_pend_r;
          state_r <= ST_DONE;
        end
        ST_DONE: begin
          done_r  <= 1'b1;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign q    = q_r;
  assign r    = r_r;
  assign dbz  = dbz_r;
  assign ovf  = ovf_r;

endmodule

// File: tb/tb_signed_divider.sv
// Scoreboard bench for signed_divider: the driver pushes reference results
// computed with integer division; a negedge monitor pops and compares on done.
module tb_signed_divider;

  localparam int AW = 16;
  localparam int BW = 8;
  localparam int LAT = 19;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] a;
  logic [BW-1:0] b;
  logic          busy, done, dbz, ovf;
  logic [AW-1:0] q;
  logic [BW-1:0] r;

  typedef struct {
    logic [AW-1:0] a;
    logic [BW-1:0] b;
    logic [AW-1:0] q;
    logic [BW-1:0] r;
    logic          dbz;
    logic          ovf;
    int            done_cyc;
  } exp_t;

  exp_t scb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;

  signed_divider #(.a_size(AW), .b_size(BW)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .q(q), .r(r), .dbz(dbz), .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  // Reference: plain truncating integer division plus the special cases.
  function automatic exp_t model(input logic [AW-1:0] av, input logic [BW-1:0] bv);
    exp_t e;
    int sa, sbv, qi, ri;
    sa  = $signed(av);
    sbv = $signed(bv);
    e.a = av;
    e.b = bv;
    e.done_cyc = 0;
    if (sbv == 0) begin
      e.q = 16'hFFFF; e.r = 8'h00; e.dbz = 1'b1; e.ovf = 1'b0;
    end else begin
      qi = sa / sbv;
      ri = sa % sbv;
      e.q = qi[AW-1:0];
      e.r = ri[BW-1:0];
      e.dbz = 1'b0;
      e.ovf = (sa == -32768) && (sbv == -1);
    end
    return e;
  endfunction

  task automatic issue(input logic [AW-1:0] av, input logic [BW-1:0] bv, input bit expect_done);
    exp_t e;
    a = av; b = bv; start = 1'b1;
    if (expect_done) begin
      e = model(av, bv);
      e.done_cyc = cyc + LAT;
      scb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || scb.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_cmp++; n_fail++;
      $display("FAIL wait_idle: timeout with %0d pending", scb.size());
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (scb.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
      end else begin
        int ri, bi;
        mon_e = scb.pop_front();
        check("latency", cyc, mon_e.done_cyc);
        check("q", {16'd0, q}, {16'd0, mon_e.q});
        check("r", {24'd0, r}, {24'd0, mon_e.r});
        check("dbz", {31'd0, dbz}, {31'd0, mon_e.dbz});
        check("ovf", {31'd0, ovf}, {31'd0, mon_e.ovf});
        ri = $signed(r);
        bi = $signed(mon_e.b);
        if (bi != 0) begin
          check("r_lt_b", {31'd0, ((ri < 0 ? -ri : ri) < (bi < 0 ? -bi : bi))}, 32'd1);
          if (ri != 0) check("r_sign", {31'd0, r[BW-1]}, {31'd0, mon_e.a[AW-1]});
        end
      end
    end
  end

  logic [AW-1:0] da[5] = '{16'd100, 16'hFF9C, 16'd100, 16'h8000, 16'd5};
  logic [BW-1:0] db[5] = '{8'd7, 8'd7, 8'hF9, 8'hFF, 8'h00};
  logic [AW-1:0] eq[5] = '{16'h000E, 16'hFFF2, 16'hFFF2, 16'h8000, 16'hFFFF};
  logic [BW-1:0] er[5] = '{8'h02, 8'hFE, 8'h02, 8'h00, 8'h00};
  logic [AW-1:0] edge_a[4] = '{16'h8000, 16'h7FFF, 16'h0000, 16'hFFFF};
  logic [BW-1:0] edge_b[5] = '{8'h80, 8'h7F, 8'hFF, 8'h01, 8'h00};

  initial begin
    exp_t held_e;
    int n;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_q", {16'd0, q}, 32'd0);
    check("rst_r", {24'd0, r}, 32'd0);
    check("rst_dbz", {31'd0, dbz}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      issue(da[i], db[i], 1'b1);
      wait_idle();
      check("dir_q", {16'd0, q}, {16'd0, eq[i]});
      check("dir_r", {24'd0, r}, {24'd0, er[i]});
      check("dir_ovf", {31'd0, ovf}, {31'd0, (i == 3)});
      check("dir_dbz", {31'd0, dbz}, {31'd0, (i == 4)});
    end

    // Back-to-back: second start lands in the first IDLE cycle (done cycle).
    issue(16'd1234, 8'd17, 1'b1);
    n = 0;
    while (!done && n < 40) begin @(negedge clk); n++; end
    check("b2b_done_seen", {31'd0, done}, 32'd1);
    issue(16'hF448, 8'hF7, 1'b1);
    wait_idle();

    // start held high with operands changing mid-flight.
    held_e = model(16'd1000, 8'd13);
    a = 16'd1000; b = 8'd13; start = 1'b1;
    held_e.done_cyc = cyc + LAT;
    scb.push_back(held_e);
    repeat (5) @(negedge clk);
    a = 16'hFFF9; b = 8'd3;
    repeat (5) @(negedge clk);
    start = 1'b0;
    wait_idle();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("hold_q", {16'd0, q}, {16'd0, held_e.q});
      check("hold_r", {24'd0, r}, {24'd0, held_e.r});
    end

    // Reset in the middle of an operation aborts it without a done pulse.
    issue(16'd30000, 8'hB3, 1'b0);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_q", {16'd0, q}, 32'd0);
    check("abort_r", {24'd0, r}, 32'd0);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    issue(16'h8000, 8'h01, 1'b1);
    wait_idle();

    for (int i = 0; i < 1000; i++) begin
      logic [AW-1:0] av;
      logic [BW-1:0] bv;
      av = AW'($urandom);
      bv = BW'($urandom);
      if ($urandom_range(7, 0) == 0) av = edge_a[$urandom_range(3, 0)];
      if ($urandom_range(7, 0) == 0) bv = edge_b[$urandom_range(4, 0)];
      issue(av, bv, 1'b1);
      wait_idle();
    end

    check("scb_empty", scb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/signed_divider.md
# signed_divider

Sequential signed integer divider, the inverse of the team's combinational signed multiplier. It accepts a two's-complement dividend and divisor and produces a quotient and remainder, with divide-by-zero and overflow flags. It uses an iterative restoring algorithm that resolves one quotient bit per cycle, behind a start/busy/done handshake. It sits beside the GSM datapath multipliers, where normalisation and gain steps need a quotient without a large combinational array.

## Interface
Parameters:
- a_size, 16, dividend and quotient width in bits (≥ 2)
- b_size, 8, divisor and remainder width in bits (≥ 2, ≤ a_size)

Ports:
- clk  input  1  single clock; all state changes on its rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  a_size  signed dividend; captured on the accepted start edge
- b  input  b_size  signed divisor; captured on the accepted start edge
- busy  output  1  high whenever state ≠ IDLE
- done  output  1  one-cycle pulse; results valid from this cycle onward
- q  output  a_size  signed quotient
- r  output  b_size  signed remainder
- dbz  output  1  divide-by-zero flag for the last operation
- ovf  output  1  overflow flag for the last operation

## Operation
- Reset values: busy=0, done=0, q=0, r=0, dbz=0, ovf=0. State is IDLE and the iteration counter is 0.
- States:
  - IDLE: start=1 captures a and b, records both signs, loads |a| and |b|, and goes to CALC.
  - CALC: a_size cycles, MSB first. Shift the partial remainder left, bring in the next dividend bit, and trial-subtract |b|. If the result is non-negative, keep it and set the quotient bit to 1; otherwise restore and set it to 0. After the last bit, go to FIX.
  - FIX: apply signs and flags, write q, r, dbz and ovf, and go to DONE.
  - DONE: done=1 for this cycle only, then go to IDLE.
- Rounding: truncation toward zero.
  - q is negated if sign(a) ≠ sign(b).
  - r takes the sign of a, and |r| < |b|.
- Width rules:
  - The partial remainder is b_size+1 bits wide.
  - |a| is formed in a_size+1 bits, so that −2^(a_size−1) is handled correctly.
- Divide by zero (b=0): the full latency is still taken. Result is dbz=1, ovf=0, q=all ones, r=0.
- Overflow (a=−2^(a_size−1) and b=−1): result is ovf=1, dbz=0, q=−2^(a_size−1) (wrapped), r=0.
- Normal result: dbz=0 and ovf=0.
- start while busy=1 is ignored and has no effect on the operation in progress.
- q, r, dbz and ovf hold their values from FIX until the FIX of the next accepted operation.
- Reset mid-operation aborts it: there is no done pulse and all outputs return to their reset values.

## Timing
- Accepted start at edge k:
  - busy=1 from edge k.
  - CALC occupies edges k+1 through k+a_size.
  - FIX ends at edge k+a_size+1, when q, r and the flags update.
  - done=1 for the cycle after edge k+a_size+2.
  - busy=0 after edge k+a_size+3.
- Latency is constant: a_size+3 cycles from start to done, regardless of operand values.
- A new start is accepted in the first IDLE cycle, which gives a back-to-back throughput of one operation per a_size+3 cycles.
- a and b need only be valid on the accepted start edge.

## Structure
- Shared package: the state encoding (IDLE, CALC, FIX, DONE), the default a_size and b_size, and a helper function for the two's-complement most-negative constant.
- One sub-module, twos_abs. It is parameterised by width, takes a signed value, and returns its magnitude plus a sign bit. It is instantiated for a and b.
- Everything else stays in signed_divider: the FSM, the counter, and the shift/subtract datapath.

## Test plan
All cases use a_size=16, b_size=8.
- a=100, b=7, start pulse → done exactly 19 cycles after start; q=14 (0x000E), r=2, dbz=0, ovf=0.
- a=−100, b=7 → q=0xFFF2 (−14), r=0xFE (−2). Then a=100, b=−7 → q=0xFFF2, r=0x02.
- a=0x8000, b=0xFF → ovf=1, q=0x8000, r=0. Then a=5, b=0 → dbz=1, q=0xFFFF, r=0, with done still at 19 cycles.
- start held high across an operation, with a and b changed mid-flight → only the first operands are used; exactly one done per accepted start; q and r are stable between done pulses.
- rst asserted at cycle 8 of an operation → next cycle busy=0, q=0, r=0, no done pulse. A fresh start then completes normally.
- Randomised check: 1,000 operand pairs compared against truncating reference division, with remainder-sign and |r|<|b| assertions.
